// File: rtl/uart_packet_receive_pkg.sv
// Shared definitions for the UART packet receiver: FSM state encoding,
// error codes reported on o_error, the default frame start marker and a
// small checksum helper.
package uart_packet_receive_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LENGTH,
    PAYLOAD,
    CHECK,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERROR_NONE     = 2'd0,
    ERROR_LENGTH   = 2'd1,
    ERROR_CHECKSUM = 2'd2
  } error_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Running checksum is a plain 8-bit wrap-around sum.
  function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] value);
    return sum + value;
  endfunction

endpackage

// File: rtl/uart_packet_receive_packet_buffer.sv
// Payload buffer for the UART packet receiver.
// DEPTH x 8 array, synchronous write, asynchronous (combinational) read.
// Ports:
//   clk           clock
//   write_enable  store write_data at write_address on the rising edge
//   write_address buffer slot to write
//   write_data    byte to store
//   read_address  buffer slot to read
//   read_data     contents of read_address (combinational)
module uart_packet_receive_packet_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          write_enable,
  input  logic [AW-1:0] write_address,
  input  logic [7:0]    write_data,
  input  logic [AW-1:0] read_address,
  output logic [7:0]    read_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  // NOTE: the array has no reset; a slot is only read after the current
  // packet has written it, so clearing it would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/uart_packet_receive.sv
// UART packet receiver: parses SYNC, LEN, LEN payload bytes, CHECKSUM from
// the UART byte stream, buffers the payload and releases it downstream with
// a last marker only when (LEN + payload + CHECKSUM) mod 256 == 0.
// Malformed frames are dropped and reported with a one-cycle o_error pulse.
// Ports:
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_data, i_data_valid, o_data_ready   byte stream from the UART receiver
//   o_payload, o_payload_valid, i_payload_ready, o_payload_last
//                                    verified payload stream to the consumer
//   o_error                          0 none, 1 length error, 2 checksum error
module uart_packet_receive
  import uart_packet_receive_pkg::*;
#(
  parameter int         MAX_LENGTH = 16,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [7:0] o_payload,
  output logic       o_payload_valid,
  input  logic       i_payload_ready,
  output logic       o_payload_last,
  output logic [1:0] o_error
);

  localparam int CW = $clog2(MAX_LENGTH + 1);
  localparam int AW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [8:0]    MAX_LEN = 9'(MAX_LENGTH);

  state_t        state, state_next;
  logic [CW-1:0] length, count, rd;
  logic [7:0]    sum;
  error_t        error;

  logic       accept, out_fire;
  logic       length_bad, payload_done, check_ok;
  logic [7:0] read_data;

  assign accept       = i_data_valid && o_data_ready;
  assign out_fire     = o_payload_valid && i_payload_ready;
  assign length_bad   = (i_data == 8'd0) || ({1'b0, i_data} > MAX_LEN);
  assign payload_done = (count == length - ONE);
  assign check_ok     = (checksum_add(sum, i_data) == 8'd0);

  // Ready depends on state only, so the UART side never sees a
  // combinational path from its own valid back to ready.
  assign o_data_ready    = (state != DRAIN);
  assign o_payload_valid = (state == DRAIN);
  assign o_payload_last  = o_payload_valid && (rd == length - ONE);
  assign o_payload       = o_payload_valid ? read_data : 8'd0;
  assign o_error         = error;

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: defaulting state_next before the case keeps every path assigned,
    // so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (accept && (i_data == SYNC_BYTE)) state_next = LENGTH;
      LENGTH:  if (accept) state_next = length_bad ? IDLE : PAYLOAD;
      PAYLOAD: if (accept && payload_done) state_next = CHECK;
      CHECK:   if (accept) state_next = check_ok ? DRAIN : IDLE;
      DRAIN:   if (out_fire && o_payload_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      length <= '0;
      count  <= '0;
      rd     <= '0;
      sum    <= '0;
      error  <= ERROR_NONE;
    end else begin
      error <= ERROR_NONE;
      case (state)
        LENGTH: if (accept) begin
          if (length_bad) begin
            error <= ERROR_LENGTH;
          end else begin
            // Validated against MAX_LENGTH, so the value fits in CW bits.
            length <= i_data[CW-1:0];
            sum    <= i_data;
            count  <= '0;
          end
        end
        PAYLOAD: if (accept) begin
          sum   <= checksum_add(sum, i_data);
          count <= count + ONE;
        end
        CHECK: if (accept) begin
          if (check_ok) rd <= '0;
          else          error <= ERROR_CHECKSUM;
        end
        DRAIN: if (out_fire) rd <= rd + ONE;
        default: ;
      endcase
    end
  end

  uart_packet_receive_packet_buffer #(
    .DEPTH(MAX_LENGTH),
    .AW   (AW)
  ) u_buffer (
    .clk          (i_clock),
    .write_enable (accept && (state == PAYLOAD)),
    .write_address(count[AW-1:0]),
    .write_data   (i_data),
    .read_address (rd[AW-1:0]),
    .read_data    (read_data)
  );

endmodule
